// File: rtl/weight_binner.sv
// Settle-qualified weight classifier: bins each new object against programmable
// upper thresholds and keeps saturating per-bin counts with sticky overflow flags.
module weight_binner #(
  parameter int W_WIDTH   = 12,
  parameter int N_BINS    = 6,
  parameter int CNT_WIDTH = 8,
  parameter int SETTLE    = 2,
  parameter int DEF_STEP  = 200,
  localparam int BIN_W    = $clog2(N_BINS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [W_WIDTH-1:0]          weight,
  input  logic                        thr_we,
  input  logic [BIN_W-1:0]            thr_idx,
  input  logic [W_WIDTH-1:0]          thr_data,
  input  logic                        clr_counts,
  output logic [N_BINS*CNT_WIDTH-1:0] counts,
  output logic [N_BINS-1:0]           sat,
  output logic [BIN_W-1:0]            curr_bin,
  output logic                        new_obj,
  output logic [BIN_W-1:0]            new_bin,
  output logic [15:0]                 obj_total
);

  // state      | meaning
  // EMPTY      | platform empty, nothing pending
  // NEW_SETTLE | new object on platform, waiting for it to settle before counting
  // LOADED     | counted object resting, curr_bin valid
  // UPD_SETTLE | load changed after counting, waiting to reclassify (no count)
  typedef enum logic [1:0] {EMPTY, NEW_SETTLE, LOADED, UPD_SETTLE} state_t;

  localparam int S_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_t               state_q, state_d;
  logic [W_WIDTH-1:0]   prev_q;
  logic [S_W-1:0]       scnt_q, scnt_d;
  logic                 settled;
  logic [W_WIDTH-1:0]   thr_q [N_BINS-1];
  logic [BIN_W-1:0]     cls_bin;
  logic [CNT_WIDTH-1:0] cnt_q [N_BINS];
  logic                 count_ev;
  logic [BIN_W-1:0]     curr_bin_d;

  // Run length of identical nonzero samples, capped at SETTLE.
  always_comb begin
    scnt_d = '0;
    if (weight != '0) begin
      if (weight == prev_q && scnt_q != '0)
        scnt_d = (scnt_q == S_W'(SETTLE)) ? scnt_q : scnt_q + 1'b1;
      else
        scnt_d = S_W'(1);
    end
  end

  assign settled = (scnt_d == S_W'(SETTLE));

  // Smallest matching threshold wins, so scan from the top down.
  always_comb begin
    cls_bin = BIN_W'(N_BINS);
    for (int i = N_BINS - 2; i >= 0; i--) begin
      if (weight <= thr_q[i])
        cls_bin = BIN_W'(i + 1);
    end
  end

  always_comb begin
    state_d    = state_q;
    count_ev   = 1'b0;
    curr_bin_d = curr_bin;
    unique case (state_q)
      EMPTY: begin
        curr_bin_d = '0;
        if (weight != '0) begin
          if (settled) begin
            count_ev   = 1'b1;
            curr_bin_d = cls_bin;
            state_d    = LOADED;
          end else begin
            state_d = NEW_SETTLE;
          end
        end
      end
      NEW_SETTLE: begin
        if (weight == '0) begin
          state_d = EMPTY;
        end else if (settled) begin
          count_ev   = 1'b1;
          curr_bin_d = cls_bin;
          state_d    = LOADED;
        end
      end
      LOADED: begin
        if (weight == '0) begin
          curr_bin_d = '0;
          state_d    = EMPTY;
        end else if (weight != prev_q) begin
          if (settled)
            curr_bin_d = cls_bin;
          else
            state_d = UPD_SETTLE;
        end
      end
      UPD_SETTLE: begin
        if (weight == '0) begin
          curr_bin_d = '0;
          state_d    = EMPTY;
        end else if (settled) begin
          curr_bin_d = cls_bin;
          state_d    = LOADED;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      prev_q    <= '0;
      scnt_q    <= '0;
      curr_bin  <= '0;
      new_obj   <= 1'b0;
      new_bin   <= '0;
      obj_total <= '0;
      for (int i = 0; i < N_BINS - 1; i++)
        thr_q[i] <= W_WIDTH'((i + 1) * DEF_STEP);
    end else begin
      state_q  <= state_d;
      prev_q   <= weight;
      scnt_q   <= scnt_d;
      curr_bin <= curr_bin_d;
      new_obj  <= count_ev;
      if (count_ev) begin
        new_bin   <= cls_bin;
        obj_total <= obj_total + 16'd1;
      end
      // Out-of-range indices match no entry and are dropped.
      for (int i = 0; i < N_BINS - 1; i++) begin
        if (thr_we && thr_idx == BIN_W'(i))
          thr_q[i] <= thr_data;
      end
    end
  end

  // A clear coinciding with a count leaves the counted bin at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat <= '0;
      for (int k = 0; k < N_BINS; k++)
        cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_BINS; k++) begin
        if (clr_counts) begin
          sat[k]   <= 1'b0;
          cnt_q[k] <= (count_ev && cls_bin == BIN_W'(k + 1)) ? CNT_WIDTH'(1) : '0;
        end else if (count_ev && cls_bin == BIN_W'(k + 1)) begin
          if (cnt_q[k] == '1)
            sat[k] <= 1'b1;
          else
            cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_BINS; k++) begin : g_cnt_out
    assign counts[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
  end

endmodule

// File: tb/tb_weight_binner.sv
// Bench for weight_binner: directed scenarios with a behavioural reference model
// compared every cycle, plus literal spot checks.
module tb_weight_binner;
  localparam int W_WIDTH = 12, N_BINS = 6, CNT_WIDTH = 8, SETTLE = 2, DEF_STEP = 200;
  localparam int BIN_W = $clog2(N_BINS + 1);

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [W_WIDTH-1:0]          weight = '0;
  logic                        thr_we = 1'b0;
  logic [BIN_W-1:0]            thr_idx = '0;
  logic [W_WIDTH-1:0]          thr_data = '0;
  logic                        clr_counts = 1'b0;
  logic [N_BINS*CNT_WIDTH-1:0] counts;
  logic [N_BINS-1:0]           sat;
  logic [BIN_W-1:0]            curr_bin;
  logic                        new_obj;
  logic [BIN_W-1:0]            new_bin;
  logic [15:0]                 obj_total;

  weight_binner #(.W_WIDTH(W_WIDTH), .N_BINS(N_BINS), .CNT_WIDTH(CNT_WIDTH),
                  .SETTLE(SETTLE), .DEF_STEP(DEF_STEP)) dut (
    .clk(clk), .reset(reset), .weight(weight), .thr_we(thr_we), .thr_idx(thr_idx),
    .thr_data(thr_data), .clr_counts(clr_counts), .counts(counts), .sat(sat),
    .curr_bin(curr_bin), .new_obj(new_obj), .new_bin(new_bin), .obj_total(obj_total)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: object-level view of the platform.
  int  m_thr [N_BINS-1];
  int  m_cnt [N_BINS];
  bit  m_sat [N_BINS];
  int  hist[$];
  bit  counted, disturbed, started = 0;
  int  load_w, m_curr, m_new_bin, m_total;
  bit  m_new_obj;

  function automatic int mbin(input int w);
    for (int i = 0; i < N_BINS - 1; i++)
      if (w <= m_thr[i]) return i + 1;
    return N_BINS;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      for (int i = 0; i < N_BINS - 1; i++) m_thr[i] = (i + 1) * DEF_STEP;
      for (int k = 0; k < N_BINS; k++) begin m_cnt[k] = 0; m_sat[k] = 0; end
      hist.delete();
      counted = 0; disturbed = 0; load_w = 0; m_curr = 0;
      m_new_bin = 0; m_total = 0; m_new_obj = 0;
    end else begin
      int w, b;
      bit st, ev;
      w = int'(weight);
      b = mbin(w);
      hist.push_back(w);
      if (hist.size() > SETTLE) void'(hist.pop_front());
      st = (w != 0) && (hist.size() == SETTLE);
      foreach (hist[j]) if (hist[j] != w) st = 0;
      ev = 0;
      if (w == 0) begin
        counted = 0; disturbed = 0; m_curr = 0;
      end else if (!counted) begin
        if (st) begin ev = 1; counted = 1; m_curr = b; load_w = w; end
      end else begin
        if (w != load_w) disturbed = 1;
        if (st && disturbed) begin m_curr = b; load_w = w; disturbed = 0; end
      end
      if (clr_counts)
        for (int k = 0; k < N_BINS; k++) begin m_cnt[k] = 0; m_sat[k] = 0; end
      if (ev) begin
        if (clr_counts) m_cnt[b-1] = 1;
        else if (m_cnt[b-1] == (1 << CNT_WIDTH) - 1) m_sat[b-1] = 1;
        else m_cnt[b-1]++;
        m_new_bin = b;
        m_total = (m_total + 1) & 16'hFFFF;
      end
      m_new_obj = ev;
      if (thr_we && int'(thr_idx) <= N_BINS - 2) m_thr[thr_idx] = int'(thr_data);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [N_BINS*CNT_WIDTH-1:0] ec;
      logic [N_BINS-1:0] es;
      for (int k = 0; k < N_BINS; k++) begin
        ec[k*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(m_cnt[k]);
        es[k] = m_sat[k];
      end
      check("model_counts", longint'(counts), longint'(ec));
      check("model_sat", longint'(sat), longint'(es));
      check("model_curr_bin", longint'(curr_bin), longint'(m_curr));
      check("model_new_obj", longint'(new_obj), longint'(m_new_obj));
      if (m_new_obj) check("model_new_bin", longint'(new_bin), longint'(m_new_bin));
      check("model_obj_total", longint'(obj_total), longint'(m_total));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int bcnt(input int k);
    return int'(counts[(k-1)*CNT_WIDTH +: CNT_WIDTH]);
  endfunction

  initial begin
    cyc(3);
    reset = 1'b0;
    check("rst_counts", longint'(counts), 0);
    check("rst_curr_bin", longint'(curr_bin), 0);
    check("rst_obj_total", longint'(obj_total), 0);

    // 350 held: count on the second edge, bin 2
    weight = 350; cyc(1);
    check("t1_no_early", longint'(new_obj), 0);
    cyc(1);
    check("t1_new_obj", longint'(new_obj), 1);
    check("t1_new_bin", longint'(new_bin), 2);
    cyc(1);
    check("t1_bin2", bcnt(2), 1);
    check("t1_curr", longint'(curr_bin), 2);
    check("t1_pulse_end", longint'(new_obj), 0);
    weight = 0; cyc(1);
    check("t1_empty", longint'(curr_bin), 0);

    // unstable then settled, and a one-cycle blip
    weight = 150; cyc(1); weight = 152; cyc(1); weight = 152; cyc(1);
    check("t2_new_bin", longint'(new_bin), 1);
    check("t2_new_obj", longint'(new_obj), 1);
    weight = 0; cyc(1); weight = 90; cyc(1); weight = 0; cyc(2);
    check("t2_bin1", bcnt(1), 1);
    check("t2_total", longint'(obj_total), 2);

    // reclassify a settled load without counting
    weight = 500; cyc(2);
    check("t3_curr3", longint'(curr_bin), 3);
    weight = 1500; cyc(1);
    check("t3_held", longint'(curr_bin), 3);
    cyc(1);
    check("t3_curr6", longint'(curr_bin), 6);
    check("t3_bin6", bcnt(6), 0);
    check("t3_total", longint'(obj_total), 3);
    weight = 0; cyc(1);
    check("t3_empty", longint'(curr_bin), 0);

    // saturation of bin 1
    reset = 1'b1; cyc(1); reset = 1'b0;
    for (int n = 0; n < 256; n++) begin
      weight = 100; cyc(2); weight = 0; cyc(1);
    end
    check("t4_bin1", bcnt(1), 255);
    check("t4_sat0", longint'(sat[0]), 1);
    check("t4_total", longint'(obj_total), 256);
    clr_counts = 1'b1; cyc(1); clr_counts = 1'b0;
    check("t4_clr_counts", longint'(counts), 0);
    check("t4_clr_sat", longint'(sat), 0);
    check("t4_total_kept", longint'(obj_total), 256);

    // threshold programming
    thr_we = 1'b1; thr_idx = 0; thr_data = 50; cyc(1); thr_we = 1'b0;
    weight = 120; cyc(2);
    check("t5_bin2", longint'(new_bin), 2);
    weight = 0; cyc(1);
    thr_we = 1'b1; thr_idx = 5; thr_data = 10; cyc(1); thr_we = 1'b0;
    weight = 900; cyc(2);
    check("t5_bin5", longint'(new_bin), 5);
    weight = 0; cyc(1);
    weight = 45; cyc(2);
    check("t5_bin1", longint'(new_bin), 1);
    weight = 0; cyc(1);
    weight = 300; cyc(1);
    clr_counts = 1'b1; cyc(1); clr_counts = 1'b0;
    check("t5_clr_ev_pulse", longint'(new_obj), 1);
    check("t5_clr_ev_bin2", bcnt(2), 1);
    check("t5_clr_ev_bin1", bcnt(1), 0);
    check("t5_clr_ev_bin5", bcnt(5), 0);
    weight = 0; cyc(1);

    // reset mid-settle with the object still present
    weight = 700; cyc(1);
    reset = 1'b1; cyc(1);
    check("t6_rst_no_ev", longint'(new_obj), 0);
    check("t6_rst_cnt", bcnt(4), 0);
    reset = 1'b0; cyc(1);
    check("t6_first", longint'(new_obj), 0);
    cyc(1);
    check("t6_new_obj", longint'(new_obj), 1);
    check("t6_new_bin", longint'(new_bin), 4);
    cyc(1);
    check("t6_bin4", bcnt(4), 1);
    weight = 0; cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
